perceptron_mac_engine: RTL and testbench

Parametrised successor to the single-neuron perceptron inference core. It holds a programmable weight/bias register file, accepts an N-element input vector over a valid/ready stream, and performs one signed multiply-accumulate per accepted element with a saturating accumulator. The result is presented on a valid/ready output port with a selectable activation (step or shifted, clipped ReLU). It sits between the pin-level I/O adapter and the top-level wrapper.

---
 rtl/perceptron_mac_engine.sv | 143 ++++++++++++++
 tb/tb_perceptron_mac_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_mac_engine.sv
// Single-neuron MAC engine: programmable weights/bias, streamed unsigned inputs,
// saturating signed accumulator and step / shifted-clipped-ReLU result port.
module perceptron_mac_engine #(
    parameter int unsigned N_INPUTS = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned ACC_W    = 20,
    parameter int unsigned SHIFT    = 4,
    parameter int unsigned AW       = $clog2(N_INPUTS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [WEIGHT_W-1:0] cfg_wdata,
    input  logic                mode,
    input  logic                x_valid,
    output logic                x_ready,
    input  logic [DATA_W-1:0]   x_data,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                y_class,
    output logic [DATA_W-1:0]   y_value,
    output logic [ACC_W-1:0]    y_acc,
    output logic                overflow,
    output logic                busy
);
    localparam int unsigned CW = $clog2(N_INPUTS);
    localparam int unsigned PW = DATA_W + WEIGHT_W + 1;
    // Sum is wide enough for either operand plus a carry, so range checks are exact.
    localparam int unsigned SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(N_INPUTS - 1);

    typedef enum logic {StAccept, StResult} state_e;

    state_e state_q, state_d;

    logic signed [WEIGHT_W-1:0] weight_q [N_INPUTS];
    logic signed [WEIGHT_W-1:0] bias_q;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [CW-1:0]              cnt_q;
    logic                       mode_q;
    logic                       overflow_q;

    logic                       accept;
    logic                       first;
    logic                       sat;
    logic signed [PW-1:0]       x_ext, w_ext, product;
    logic signed [SW-1:0]       base, sum;
    logic [ACC_W-1:0]           shifted;

    assign accept = x_valid & x_ready;
    assign first  = (cnt_q == '0);
    assign busy   = !first || (state_q == StResult);

    always_comb begin
        x_ext   = {{(PW-DATA_W){1'b0}}, x_data};
        w_ext   = {{(PW-WEIGHT_W){weight_q[cnt_q][WEIGHT_W-1]}}, weight_q[cnt_q]};
        product = x_ext * w_ext;
        base    = first ? {{(SW-WEIGHT_W){bias_q[WEIGHT_W-1]}}, bias_q}
                        : {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        sum     = base + {{(SW-PW){product[PW-1]}}, product};
        sat     = 1'b0;
        acc_d   = sum[ACC_W-1:0];
        if (sum > ACC_MAX) begin
            acc_d = ACC_MAX[ACC_W-1:0];
            sat   = 1'b1;
        end else if (sum < ACC_MIN) begin
            acc_d = ACC_MIN[ACC_W-1:0];
            sat   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            overflow_q <= 1'b0;
            bias_q     <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                acc_q      <= acc_d;
                cnt_q      <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                overflow_q <= (first ? 1'b0 : overflow_q) | sat;
                if (first) begin
                    mode_q <= mode;
                end
            end
            // Locked while a vector is in flight so all elements see one weight set.
            if (cfg_we && !busy) begin
                if (cfg_addr < AW'(N_INPUTS)) begin
                    weight_q[cfg_addr[CW-1:0]] <= cfg_wdata;
                end else if (cfg_addr == AW'(N_INPUTS)) begin
                    bias_q <= cfg_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccept;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccept: if (accept && (cnt_q == LAST)) state_d = StResult;
            StResult: if (y_ready) state_d = StAccept;
            default:  state_d = StAccept;
        endcase
    end

    always_comb begin
        x_ready = (state_q == StAccept);
        y_valid = (state_q == StResult);
    end

    always_comb begin
        y_acc    = acc_q;
        overflow = overflow_q;
        y_class  = ~acc_q[ACC_W-1];
        shifted  = $unsigned(acc_q) >> SHIFT;
        if (!mode_q) begin
            y_value = {{(DATA_W-1){1'b0}}, y_class};
        end else if (acc_q[ACC_W-1]) begin
            y_value = '0;
        end else if (|shifted[ACC_W-1:DATA_W]) begin
            y_value = '1;
        end else begin
            y_value = shifted[DATA_W-1:0];
        end
    end
endmodule

// File: tb/tb_perceptron_mac_engine.sv
// Randomised bench for perceptron_mac_engine against an arithmetic reference model.
module tb_perceptron_mac_engine;
    localparam int N = 4;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int ACCW = 16;
    localparam int SH = 2;
    localparam int AWID = 3;
    localparam int ACC_MAX_I = (1 << (ACCW - 1)) - 1;
    localparam int ACC_MIN_I = -(1 << (ACCW - 1));
    localparam int VMAX = (1 << DW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [AWID-1:0] cfg_addr;
    logic [WW-1:0]   cfg_wdata;
    logic            mode;
    logic            x_valid;
    logic            x_ready;
    logic [DW-1:0]   x_data;
    logic            y_valid;
    logic            y_ready;
    logic            y_class;
    logic [DW-1:0]   y_value;
    logic [ACCW-1:0] y_acc;
    logic            overflow;
    logic            busy;

    perceptron_mac_engine #(
        .N_INPUTS(N), .DATA_W(DW), .WEIGHT_W(WW), .ACC_W(ACCW), .SHIFT(SH), .AW(AWID)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .mode(mode), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_class(y_class), .y_value(y_value),
        .y_acc(y_acc), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    int m_w[N];
    int m_bias, m_acc, m_cnt;
    bit m_mode, m_ovf, m_result;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_value();
        int s;
        if (!m_mode) return (m_acc >= 0) ? 1 : 0;
        if (m_acc < 0) return 0;
        s = m_acc >>> SH;
        return (s > VMAX) ? VMAX : s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_w[i] = 0;
        m_bias = 0; m_acc = 0; m_cnt = 0;
        m_mode = 0; m_ovf = 0; m_result = 0;
    endtask

    task automatic model_elem(input int d, input bit md);
        int sum;
        if (m_cnt == 0) begin
            m_mode = md;
            m_ovf = 0;
            sum = m_bias;
        end else begin
            sum = m_acc;
        end
        sum += d * m_w[m_cnt];
        if (sum > ACC_MAX_I) begin
            sum = ACC_MAX_I; m_ovf = 1;
        end else if (sum < ACC_MIN_I) begin
            sum = ACC_MIN_I; m_ovf = 1;
        end
        m_acc = sum;
        m_cnt++;
        if (m_cnt == N) begin
            m_cnt = 0;
            m_result = 1;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_acc"}, $signed(y_acc), m_acc);
        chk({tag, "_ovf"}, overflow, m_ovf);
        chk({tag, "_x_ready"}, x_ready, m_result ? 0 : 1);
        chk({tag, "_y_valid"}, y_valid, m_result ? 1 : 0);
        chk({tag, "_busy"}, busy, (m_result || m_cnt != 0) ? 1 : 0);
        if (m_result) begin
            chk({tag, "_class"}, y_class, (m_acc >= 0) ? 1 : 0);
            chk({tag, "_value"}, y_value, exp_value());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_state("rst");
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we = 1'b1;
        cfg_addr = addr[AWID-1:0];
        cfg_wdata = data[WW-1:0];
        @(negedge clk);
        cfg_we = 1'b0;
        if (!(m_result || m_cnt != 0)) begin
            if (addr < N) m_w[addr] = data;
            else if (addr == N) m_bias = data;
        end
    endtask

    task automatic send_elem(input int d, input bit md);
        chk("x_ready_pre", x_ready, 1);
        x_valid = 1'b1;
        x_data = d[DW-1:0];
        mode = md;
        @(negedge clk);
        x_valid = 1'b0;
        x_data = DW'($urandom);
        mode = 1'($urandom);
        model_elem(d, md);
        check_state("elem");
    endtask

    task automatic finish_vec(input int hold);
        check_state("res");
        for (int i = 0; i < hold; i++) begin
            x_valid = 1'b1;
            x_data = DW'($urandom);
            @(negedge clk);
            check_state("hold");
        end
        x_valid = 1'b0;
        y_ready = 1'b1;
        @(negedge clk);
        y_ready = 1'b0;
        m_result = 0;
        check_state("ack");
    endtask

    // Gaps between elements may carry random config writes the model decides to keep or drop.
    task automatic run_vec(input int a, input int b, input int c, input int d,
                           input bit md, input int hold, input bit rnd);
        int v[N];
        v = '{a, b, c, d};
        for (int i = 0; i < N; i++) begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                cfg_write($urandom_range(0, 7), $urandom_range(0, 255) - 128);
            end
            send_elem(v[i], md);
        end
        finish_vec(hold);
    endtask

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3,
                               input int b);
        cfg_write(0, w0); cfg_write(1, w1); cfg_write(2, w2); cfg_write(3, w3);
        cfg_write(N, b);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; mode = 0;
        x_valid = 0; x_data = 0; y_ready = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_state("init");

        // Basic MAC
        set_weights(1, 2, -1, 3, -5);
        run_vec(10, 20, 30, 40, 1, 0, 0);
        chk("basic_acc_value", m_acc, 135);

        // Negative in step then ReLU mode
        set_weights(-1, -1, -1, -1, 0);
        run_vec(1, 1, 1, 1, 0, 0, 0);
        run_vec(1, 1, 1, 1, 1, 1, 0);

        // Saturation, then overflow clears on the next vector
        set_weights(127, 127, 127, 127, 127);
        run_vec(255, 255, 255, 255, 1, 0, 0);
        run_vec(0, 0, 0, 0, 1, 0, 0);

        // Negative saturation
        set_weights(-128, -128, -128, -128, -128);
        run_vec(255, 255, 255, 255, 1, 0, 0);

        // Backpressure
        set_weights(3, -2, 5, 1, 7);
        run_vec(9, 200, 77, 13, 1, 5, 0);
        run_vec(1, 2, 3, 4, 0, 0, 0);

        // Config lock mid-vector, then the same write while idle
        set_weights(1, 1, 1, 1, 0);
        send_elem(10, 1);
        send_elem(10, 1);
        cfg_write(3, 100);
        send_elem(10, 1);
        send_elem(10, 1);
        finish_vec(0);
        cfg_write(3, 100);
        cfg_write(7, 55);
        run_vec(10, 10, 10, 10, 1, 0, 0);

        // Reset mid-vector
        send_elem(50, 1);
        send_elem(60, 1);
        do_reset();
        run_vec($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), 1, 0, 0);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            for (int a = 0; a <= N; a++) begin
                if ($urandom_range(0, 1) == 1) cfg_write(a, $urandom_range(0, 255) - 128);
            end
            if ($urandom_range(0, 3) == 0) begin
                run_vec(255, 255, $urandom_range(200, 255), 255, 1'($urandom),
                        $urandom_range(0, 3), 1);
            end else begin
                run_vec($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 255), 1'($urandom), $urandom_range(0, 3), 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
